// File: rtl/lcd_hd44780_drv.sv
//------------------------------------------------------------------------------
// Module      : lcd_hd44780_drv
// Description : Buffers LCD command/data words in a FIFO and replays each one
//               onto HD44780 pins with setup, enable-pulse, hold and exec timing.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcd_hd44780_drv #(
  parameter int FIFO_DEPTH  = 8,
  parameter int T_SETUP     = 2,
  parameter int T_PW        = 12,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_lcd_word,
  input  logic        i_lcd_vld,
  output logic        o_full,
  output logic        o_ovf,
  output logic        o_busy,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data
);

  localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CW = c_AW + 1;

  localparam int c_TMAX_A = (T_SETUP > T_PW) ? T_SETUP : T_PW;
  localparam int c_TMAX_B = (T_HOLD > T_EXEC) ? T_HOLD : T_EXEC;
  localparam int c_TMAX_C = (c_TMAX_A > c_TMAX_B) ? c_TMAX_A : c_TMAX_B;
  localparam int c_TMAX   = (c_TMAX_C > T_EXEC_LONG) ? c_TMAX_C : T_EXEC_LONG;
  localparam int c_TW     = $clog2(c_TMAX + 1);

  localparam logic [c_TW-1:0] c_LD_SETUP = c_TW'(T_SETUP - 1);
  localparam logic [c_TW-1:0] c_LD_PW    = c_TW'(T_PW - 1);
  localparam logic [c_TW-1:0] c_LD_HOLD  = c_TW'(T_HOLD - 1);
  localparam logic [c_TW-1:0] c_LD_EXEC  = c_TW'(T_EXEC - 1);
  localparam logic [c_TW-1:0] c_LD_LONG  = c_TW'(T_EXEC_LONG - 1);
  localparam logic [c_CW-1:0] c_DEPTH    = c_CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;

  // Entry layout: {ON, RS, DATA[7:0]}
  logic [9:0]      r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_CW-1:0] r_count;
  logic            r_ovf;

  logic [2:0]      r_state;
  logic [c_TW-1:0] r_timer;
  logic            r_en;
  logic            r_on;
  logic            r_rs;
  logic [7:0]      r_data;

  logic            w_push;
  logic            w_pop;
  logic            w_timer_zero;
  logic            w_long;
  logic [9:0]      w_head;
  logic [9:0]      w_in;
  logic            w_unused_bits;

  assign w_in          = {i_lcd_word[31], i_lcd_word[9], i_lcd_word[7:0]};
  assign w_unused_bits = ^{i_lcd_word[30:10], i_lcd_word[8]};
  assign w_head        = r_mem[r_rptr];

  assign o_full       = (r_count == c_DEPTH);
  assign w_push       = i_lcd_vld && !o_full;
  assign w_pop        = (r_state == S_IDLE) && (r_count != '0);
  assign w_timer_zero = (r_timer == '0);
  // Clear and return-home need the long execution wait.
  assign w_long       = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02) ||
                                  (r_data == 8'h03));

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
      if (i_lcd_vld && o_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_en    <= 1'b0;
      r_on    <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_en <= 1'b0;
          if (w_pop) begin
            r_on    <= w_head[9];
            r_rs    <= w_head[8];
            r_data  <= w_head[7:0];
            r_timer <= c_LD_SETUP;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_timer_zero) begin
            r_en    <= 1'b1;
            r_timer <= c_LD_PW;
            r_state <= S_PULSE;
          end else begin
            r_timer <= r_timer - c_TW'(1);
          end
        end
        S_PULSE: begin
          if (w_timer_zero) begin
            r_en    <= 1'b0;
            r_timer <= c_LD_HOLD;
            r_state <= S_HOLD;
          end else begin
            r_timer <= r_timer - c_TW'(1);
          end
        end
        S_HOLD: begin
          if (w_timer_zero) begin
            r_timer <= w_long ? c_LD_LONG : c_LD_EXEC;
            r_state <= S_EXEC;
          end else begin
            r_timer <= r_timer - c_TW'(1);
          end
        end
        S_EXEC: begin
          if (w_timer_zero) begin
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer - c_TW'(1);
          end
        end
        default: begin
          r_en    <= 1'b0;
          r_timer <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ovf      = r_ovf;
  assign o_busy     = (r_state != S_IDLE) || (r_count != '0);
  assign o_lcd_on   = r_on;
  assign o_lcd_en   = r_en;
  assign o_lcd_rs   = r_rs;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_data = r_data;

endmodule

`default_nettype wire

// File: tb/tb_lcd_hd44780_drv.sv
//------------------------------------------------------------------------------
// Module      : tb_lcd_hd44780_drv
// Description : Self-checking bench for lcd_hd44780_drv against a timeline model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lcd_hd44780_drv;

  localparam int c_DEPTH = 4;
  localparam int c_TS    = 2;
  localparam int c_TPW   = 3;
  localparam int c_TH    = 1;
  localparam int c_TE    = 5;
  localparam int c_TEL   = 20;

  logic        r_clk = 1'b0;
  logic        r_rst = 1'b1;
  logic [31:0] r_word = '0;
  logic        r_vld = 1'b0;
  logic        w_full, w_ovf, w_busy, w_on, w_en, w_rs, w_rw;
  logic [7:0]  w_data;

  lcd_hd44780_drv #(
    .FIFO_DEPTH (c_DEPTH),
    .T_SETUP    (c_TS),
    .T_PW       (c_TPW),
    .T_HOLD     (c_TH),
    .T_EXEC     (c_TE),
    .T_EXEC_LONG(c_TEL)
  ) u_dut (
    .i_clk     (r_clk),
    .i_rst     (r_rst),
    .i_lcd_word(r_word),
    .i_lcd_vld (r_vld),
    .o_full    (w_full),
    .o_ovf     (w_ovf),
    .o_busy    (w_busy),
    .o_lcd_on  (w_on),
    .o_lcd_en  (w_en),
    .o_lcd_rs  (w_rs),
    .o_lcd_rw  (w_rw),
    .o_lcd_data(w_data)
  );

  always #5 r_clk = ~r_clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_rise   = 0;
  logic r_prev_en = 1'b0;

  // Model: pending queue plus the edge window of the transfer on the pins.
  logic [9:0] m_q[$];
  longint     m_cyc = 0;
  longint     m_s   = -1000;
  longint     m_f   = -1;
  logic [9:0] m_cur = '0;
  logic       m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, m_cyc);
    end
  endtask

  function automatic int exec_len(input logic [9:0] e);
    return (!e[8] && (e[7:0] >= 8'd1) && (e[7:0] <= 8'd3)) ? c_TEL : c_TE;
  endfunction

  function automatic logic m_en();
    return (m_cyc >= m_s + c_TS) && (m_cyc < m_s + c_TS + c_TPW);
  endfunction

  function automatic logic m_busy();
    return (m_cyc < m_f) || (m_q.size() != 0);
  endfunction

  function automatic logic m_in_exec();
    return (m_cyc >= m_s + c_TS + c_TPW + c_TH) && (m_cyc < m_f);
  endfunction

  task automatic model_edge(input logic vld, input logic [31:0] w, input logic rst);
    int pre;
    pre = m_q.size();
    m_cyc++;
    if (rst) begin
      m_q.delete();
      m_s   = -1000;
      m_f   = -1;
      m_cur = '0;
      m_ovf = 1'b0;
    end else begin
      if ((m_cyc > m_f) && (pre != 0)) begin
        m_cur = m_q.pop_front();
        m_s   = m_cyc;
        m_f   = m_cyc + c_TS + c_TPW + c_TH + exec_len(m_cur);
      end
      if (vld) begin
        if (pre == c_DEPTH) m_ovf = 1'b1;
        else m_q.push_back({w[31], w[9], w[7:0]});
      end
    end
  endtask

  task automatic step(input logic vld, input logic [31:0] w, input logic rst);
    r_vld  = vld;
    r_word = w;
    r_rst  = rst;
    @(posedge r_clk);
    model_edge(vld, w, rst);
    #1;
    chk("en",   {31'b0, w_en},   {31'b0, m_en()});
    chk("on",   {31'b0, w_on},   {31'b0, m_cur[9]});
    chk("rs",   {31'b0, w_rs},   {31'b0, m_cur[8]});
    chk("data", {24'b0, w_data}, {24'b0, m_cur[7:0]});
    chk("rw",   {31'b0, w_rw},   32'd0);
    chk("busy", {31'b0, w_busy}, {31'b0, m_busy()});
    chk("full", {31'b0, w_full}, {31'b0, (m_q.size() == c_DEPTH)});
    chk("ovf",  {31'b0, w_ovf},  {31'b0, m_ovf});
    if (w_en && !r_prev_en) n_rise++;
    r_prev_en = w_en;
    r_vld = 1'b0;
    r_rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_busy() && n < 500) begin
      step(1'b0, 32'h0, 1'b0);
      n++;
    end
    chk("drain_bound", {31'b0, (n < 500)}, 32'd1);
    step(1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    int n;
    logic [31:0] w;

    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("rst_busy", {31'b0, w_busy}, 32'd0);
    chk("rst_data", {24'b0, w_data}, 32'd0);

    // Single data write, then clear command (long exec).
    step(1'b1, 32'h8000_0241, 1'b0);
    drain();
    step(1'b1, 32'h8000_0001, 1'b0);
    drain();

    // Wrap-around: ten sequential writes.
    for (int i = 0; i < 10; i++) begin
      w = $urandom;
      w[31] = 1'b1;
      w[9]  = 1'b1;
      w[7:0] = 8'h40 + 8'(i);
      step(1'b1, w, 1'b0);
      drain();
    end
    chk("wrap_ovf", {31'b0, w_ovf}, 32'd0);

    // Push during EXEC of a prior write.
    step(1'b1, 32'h8000_0241, 1'b0);
    n = 0;
    while (!m_in_exec() && n < 50) begin step(1'b0, 32'h0, 1'b0); n++; end
    chk("exec_wait", {31'b0, (n < 50)}, 32'd1);
    step(1'b1, 32'h8000_0242, 1'b0);
    drain();

    // Burst of six back-to-back writes into a depth-4 FIFO.
    n_rise = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 32'h8000_0230 + 32'(i), 1'b0);
    drain();
    chk("burst_pulses", n_rise, 32'd5);
    chk("burst_ovf", {31'b0, w_ovf}, 32'd1);

    // Reset while EN is high, with two entries still queued.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h8000_0250 + 32'(i), 1'b0);
    n = 0;
    while (!m_en() && n < 50) begin step(1'b0, 32'h0, 1'b0); n++; end
    chk("pulse_wait", {31'b0, (n < 50)}, 32'd1);
    step(1'b0, 32'h0, 1'b1);
    chk("prst_en",   {31'b0, w_en},   32'd0);
    chk("prst_on",   {31'b0, w_on},   32'd0);
    chk("prst_data", {24'b0, w_data}, 32'd0);
    chk("prst_busy", {31'b0, w_busy}, 32'd0);
    chk("prst_ovf",  {31'b0, w_ovf},  32'd0);
    n_rise = 0;
    for (int i = 0; i < 40; i++) step(1'b0, 32'h0, 1'b0);
    chk("prst_pulses", n_rise, 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      w = $urandom;
      if ($urandom_range(3) == 0) w[7:0] = 8'($urandom_range(3));
      step(($urandom_range(5) == 0), w, ($urandom_range(250) == 0));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
